voq_egress_reader: RTL

// - Read side of the shared-memory switch: drains the per-output second-stage VOQs through their rd_en/rd_sel/empty interface.
// - One round-robin reader per output port; each picks a non-empty source queue and issues a read.
// - Captured words go to a credit-protected egress buffer, then out on a valid/ready stream tagged with the source port.
// - Sits between the switch output and the egress MACs/sinks.

---
 rtl/voq_egress_reader_pkg.sv | 21 ++
 rtl/voq_egress_reader_port.sv | 141 ++++++++++++++
 rtl/voq_egress_reader.sv | 41 ++++
 3 files changed

// File: rtl/voq_egress_reader_pkg.sv
// Shared sizing constants and helpers for the VOQ egress reader.
package voq_egress_reader_pkg;
    localparam int PORT_NUB_TOTAL = 4;
    localparam int DATA_WIDTH     = 8;
    localparam int DEPTH          = 4;
    localparam int RD_LATENCY_DEF = 1;

    typedef enum logic [1:0] {
        CR_HOLD,
        CR_TAKE,
        CR_RETURN
    } credit_op_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/voq_egress_reader_port.sv
// One output port: round-robin VOQ reader, credit counter, tag pipe and
// registered-head egress FIFO.
module voq_egress_reader_port
    import voq_egress_reader_pkg::*;
#(
    parameter int N          = PORT_NUB_TOTAL,
    parameter int DW         = DATA_WIDTH,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int BUF_DEPTH  = DEPTH,
    localparam int WSEL      = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    empty,
    input  logic [DW-1:0]   voq_data,
    output logic [WSEL-1:0] rd_sel,
    output logic            rd_en,
    output logic [DW-1:0]   egress_data,
    output logic [WSEL-1:0] egress_src,
    output logic            egress_valid,
    input  logic            egress_ready
);
    localparam int CW = credit_width(BUF_DEPTH);

    if (BUF_DEPTH < 2) begin : g_bad_depth
        $error("voq_egress_reader_port: BUF_DEPTH must be >= 2");
    end
    if (RD_LATENCY < 1) begin : g_bad_latency
        $error("voq_egress_reader_port: RD_LATENCY must be >= 1");
    end

    logic [WSEL-1:0]       ptr;
    logic [WSEL-1:0]       sel_q;
    logic [WSEL-1:0]       grant;
    logic [WSEL-1:0]       idx;
    logic                  any_req;
    logic [CW-1:0]         credit;
    credit_op_e            credit_op;
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [WSEL-1:0]       pipe_tag [RD_LATENCY];
    logic [DW-1:0]         buf_data [BUF_DEPTH];
    logic [WSEL-1:0]       buf_src  [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]  buf_vld;
    logic [DW-1:0]         nxt_data [BUF_DEPTH];
    logic [WSEL-1:0]       nxt_src  [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]  nxt_vld;
    logic                  placed;
    logic                  push;
    logic                  pop;

    always_comb begin
        grant   = ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = WSEL'((int'(ptr) + k) % N);
            if (!any_req && !empty[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

    // Reads are suppressed during reset so no VOQ word is consumed and then discarded.
    assign rd_en  = !rst && any_req && (credit != '0);
    assign rd_sel = rd_en ? grant : sel_q;

    assign push         = pipe_vld[RD_LATENCY-1];
    assign egress_valid = buf_vld[0];
    assign egress_data  = buf_data[0];
    assign egress_src   = buf_src[0];
    assign pop          = egress_valid && egress_ready;

    always_comb begin
        credit_op = CR_HOLD;
        if (rd_en && !pop) begin
            credit_op = CR_TAKE;
        end else if (!rd_en && pop) begin
            credit_op = CR_RETURN;
        end
    end

    // Shift FIFO: entry 0 is the registered head; a push lands in the first free slot after any pop.
    always_comb begin
        nxt_data = buf_data;
        nxt_src  = buf_src;
        nxt_vld  = buf_vld;
        placed   = 1'b0;
        if (pop) begin
            for (int k = 0; k < BUF_DEPTH - 1; k++) begin
                nxt_data[k] = buf_data[k+1];
                nxt_src[k]  = buf_src[k+1];
            end
            nxt_vld = buf_vld >> 1;
        end
        for (int k = 0; k < BUF_DEPTH; k++) begin
            if (push && !placed && !nxt_vld[k]) begin
                nxt_data[k] = voq_data;
                nxt_src[k]  = pipe_tag[RD_LATENCY-1];
                nxt_vld[k]  = 1'b1;
                placed      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            sel_q    <= '0;
            credit   <= CW'(BUF_DEPTH);
            pipe_vld <= '0;
            buf_vld  <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_tag[k] <= '0;
            end
            for (int k = 0; k < BUF_DEPTH; k++) begin
                buf_data[k] <= '0;
                buf_src[k]  <= '0;
            end
        end else begin
            if (rd_en) begin
                ptr   <= (int'(grant) == N - 1) ? '0 : grant + WSEL'(1);
                sel_q <= grant;
            end
            case (credit_op)
                CR_TAKE:   credit <= credit - CW'(1);
                CR_RETURN: credit <= credit + CW'(1);
                default:   credit <= credit;
            endcase
            pipe_vld[0] <= rd_en;
            pipe_tag[0] <= grant;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_tag[k] <= pipe_tag[k-1];
            end
            buf_vld  <= nxt_vld;
            buf_data <= nxt_data;
            buf_src  <= nxt_src;
        end
    end
endmodule

// File: rtl/voq_egress_reader.sv
// Read side of the shared-memory switch: one independent egress reader per output port.
module voq_egress_reader
    import voq_egress_reader_pkg::*;
#(
    parameter int NUM_PORTS  = PORT_NUB_TOTAL,
    parameter int DW         = DATA_WIDTH,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int BUF_DEPTH  = DEPTH,
    localparam int WIDTH_SEL = sel_width(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS*DW-1:0]        voq_data,
    output logic [NUM_PORTS*WIDTH_SEL-1:0] rd_sel,
    output logic [NUM_PORTS-1:0]           rd_en,
    output logic [NUM_PORTS*DW-1:0]        egress_data,
    output logic [NUM_PORTS*WIDTH_SEL-1:0] egress_src,
    output logic [NUM_PORTS-1:0]           egress_valid,
    input  logic [NUM_PORTS-1:0]           egress_ready
);
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        voq_egress_reader_port #(
            .N          (NUM_PORTS),
            .DW         (DW),
            .RD_LATENCY (RD_LATENCY),
            .BUF_DEPTH  (BUF_DEPTH)
        ) u_port (
            .clk          (clk),
            .rst          (rst),
            .empty        (empty[i*NUM_PORTS +: NUM_PORTS]),
            .voq_data     (voq_data[i*DW +: DW]),
            .rd_sel       (rd_sel[i*WIDTH_SEL +: WIDTH_SEL]),
            .rd_en        (rd_en[i]),
            .egress_data  (egress_data[i*DW +: DW]),
            .egress_src   (egress_src[i*WIDTH_SEL +: WIDTH_SEL]),
            .egress_valid (egress_valid[i]),
            .egress_ready (egress_ready[i])
        );
    end
endmodule
